prism_sp_puzzle_hw_gem_dma_read_mq: RTL and testbench

Multi-queue TX DMA read stage for the GEM transmit path. It takes per-queue TX fragment cookies, arbitrates round-robin between queues at frame boundaries, and issues one DMA read per fragment. It accumulates the frame length across fragments, emits one meta descriptor per frame (size, nocrc, oversize, queue), and forwards each fragment cookie to the next stage. Compared with the single-queue predecessor, it adds N queues, backpressure on the meta FIFO, zero-length fragment bypass, and length saturation with oversize flagging.

---
 rtl/prism_sp_puzzle_hw_gem_dma_read_mq.sv | 204 ++++++++++++++++++++
 tb/tb_prism_sp_puzzle_hw_gem_dma_read_mq.sv | 477 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prism_sp_puzzle_hw_gem_dma_read_mq.sv
// Multi-queue GEM TX DMA read stage: round-robin per frame, one DMA read
// per fragment, one meta descriptor per frame, cookies forwarded downstream.
// Ports: clock/resetn (sync, active-low); q_* per-queue cookie FIFO heads
// and read pulses; dma_* read request to the DMA engine; meta_* per-frame
// descriptor writes; oc_* forwarded fragment cookies.
module prism_sp_puzzle_hw_gem_dma_read_mq #(
  parameter int NUM_QUEUES    = 4,
  parameter int ADDR_WIDTH    = 32,
  parameter int SIZE_WIDTH    = 14,
  parameter int MAX_FRAME_LEN = 1536,
  parameter int QW = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1
) (
  input  logic                             clock,
  input  logic                             resetn,
  input  logic [NUM_QUEUES-1:0]            q_empty,
  output logic [NUM_QUEUES-1:0]            q_rd_en,
  input  logic [NUM_QUEUES*ADDR_WIDTH-1:0] q_addr,
  input  logic [NUM_QUEUES*SIZE_WIDTH-1:0] q_size,
  input  logic [NUM_QUEUES-1:0]            q_eof,
  input  logic [NUM_QUEUES-1:0]            q_nocrc,
  output logic                             dma_start,
  output logic [ADDR_WIDTH-1:0]            dma_addr,
  output logic [SIZE_WIDTH-1:0]            dma_len,
  output logic                             dma_cont,
  input  logic                             dma_busy,
  input  logic                             meta_full,
  output logic                             meta_wr_en,
  output logic [SIZE_WIDTH-1:0]            meta_size,
  output logic                             meta_nocrc,
  output logic                             meta_oversize,
  output logic [QW-1:0]                    meta_queue,
  input  logic                             oc_full,
  output logic                             oc_wr_en,
  output logic [ADDR_WIDTH-1:0]            oc_addr,
  output logic [SIZE_WIDTH-1:0]            oc_size,
  output logic                             oc_eof,
  output logic [QW-1:0]                    oc_queue
);

  typedef enum logic [1:0] {
    IDLE, PREBUSY, BUSY, WAIT_OUT
  } state_t;

  localparam logic [31:0] MAXL = MAX_FRAME_LEN;

  state_t                state;
  logic                  locked;
  logic                  sof;
  logic                  sat;
  logic                  nocrc_r;
  logic                  oc_pend;
  logic                  meta_pend;
  logic [QW-1:0]         rr_ptr;
  logic [QW-1:0]         cur_q;
  logic [QW-1:0]         next_ptr;
  logic [SIZE_WIDTH-1:0] acc;

  logic                  sel_ok;
  logic [QW-1:0]         sel_q;
  logic [NUM_QUEUES-1:0] sel_oh;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [SIZE_WIDTH-1:0] sel_size;
  logic                  sel_eof;
  logic                  sel_nocrc;
  logic [SIZE_WIDTH:0]   sum;
  logic                  oc_go;
  logic                  meta_go;
  logic                  out_done;
  int                    idx;

  // Mid-frame only the owning queue may continue; otherwise scan
  // from rr_ptr, iterating backwards so the nearest queue wins.
  always_comb begin
    sel_ok = 1'b0;
    sel_q  = '0;
    idx    = 0;
    if (locked) begin
      sel_ok = ~q_empty[cur_q];
      sel_q  = cur_q;
    end else begin
      for (int i = NUM_QUEUES - 1; i >= 0; i--) begin
        idx = (int'(rr_ptr) + i) % NUM_QUEUES;
        if (!q_empty[idx]) begin
          sel_ok = 1'b1;
          sel_q  = QW'(idx);
        end
      end
    end
    sel_oh        = '0;
    sel_oh[sel_q] = 1'b1;
  end

  always_comb begin
    sel_addr  = q_addr[sel_q*ADDR_WIDTH +: ADDR_WIDTH];
    sel_size  = q_size[sel_q*SIZE_WIDTH +: SIZE_WIDTH];
    sel_eof   = q_eof[sel_q];
    sel_nocrc = q_nocrc[sel_q];
    sum       = {1'b0, acc} + {1'b0, sel_size};
    next_ptr  = (32'(cur_q) == NUM_QUEUES - 1) ? '0 : cur_q + 1'b1;
    oc_go     = oc_pend & ~oc_full;
    meta_go   = meta_pend & ~meta_full;
    out_done  = (~oc_pend | oc_go) & (~meta_pend | meta_go);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state         <= IDLE;
      locked        <= 1'b0;
      sof           <= 1'b1;
      sat           <= 1'b0;
      nocrc_r       <= 1'b0;
      oc_pend       <= 1'b0;
      meta_pend     <= 1'b0;
      rr_ptr        <= '0;
      cur_q         <= '0;
      acc           <= '0;
      q_rd_en       <= '0;
      dma_start     <= 1'b0;
      dma_addr      <= '0;
      dma_len       <= '0;
      dma_cont      <= 1'b0;
      meta_wr_en    <= 1'b0;
      meta_size     <= '0;
      meta_nocrc    <= 1'b0;
      meta_oversize <= 1'b0;
      meta_queue    <= '0;
      oc_wr_en      <= 1'b0;
      oc_addr       <= '0;
      oc_size       <= '0;
      oc_eof        <= 1'b0;
      oc_queue      <= '0;
    end else begin
      q_rd_en    <= '0;
      dma_start  <= 1'b0;
      meta_wr_en <= 1'b0;
      oc_wr_en   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (sel_ok) begin
            q_rd_en   <= sel_oh;
            oc_addr   <= sel_addr;
            oc_size   <= sel_size;
            oc_eof    <= sel_eof;
            oc_queue  <= sel_q;
            cur_q     <= sel_q;
            locked    <= ~sel_eof;
            oc_pend   <= 1'b1;
            meta_pend <= sel_eof;
            if (sof) begin
              nocrc_r <= sel_nocrc;
              sof     <= 1'b0;
            end
            // Carry out of the accumulator pins it at all-ones.
            if (sum[SIZE_WIDTH]) begin
              acc <= '1;
              sat <= 1'b1;
            end else begin
              acc <= sum[SIZE_WIDTH-1:0];
            end
            // Zero-length fragments skip the DMA entirely.
            if (sel_size != '0) begin
              dma_start <= 1'b1;
              dma_addr  <= sel_addr;
              dma_len   <= sel_size;
              dma_cont  <= ~sel_eof;
              state     <= PREBUSY;
            end else begin
              state <= WAIT_OUT;
            end
          end
        end
        PREBUSY: state <= BUSY;
        BUSY: begin
          if (!dma_busy) state <= WAIT_OUT;
        end
        WAIT_OUT: begin
          if (oc_go) begin
            oc_wr_en <= 1'b1;
            oc_pend  <= 1'b0;
          end
          if (meta_go) begin
            meta_wr_en    <= 1'b1;
            meta_size     <= acc;
            meta_nocrc    <= nocrc_r;
            meta_oversize <= sat | (32'(acc) > MAXL);
            meta_queue    <= cur_q;
            meta_pend     <= 1'b0;
          end
          if (out_done) begin
            state <= IDLE;
            if (oc_eof) begin
              acc    <= '0;
              sat    <= 1'b0;
              sof    <= 1'b1;
              rr_ptr <= next_ptr;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prism_sp_puzzle_hw_gem_dma_read_mq.sv
// Self-checking bench for prism_sp_puzzle_hw_gem_dma_read_mq: directed
// vectors, corner sequences and a randomized run against a frame model.
module tb_prism_sp_puzzle_hw_gem_dma_read_mq;

  localparam int NQ = 4;
  localparam int AW = 32;
  localparam int SW = 14;

  typedef struct {
    logic [31:0] addr;
    int          size;
    logic        eof;
    logic        nocrc;
  } cookie_t;

  typedef struct {
    int          cyc;
    int          q;
    logic [31:0] addr;
    logic [13:0] size;
    logic        f1;
    logic        f2;
  } rec_t;

  typedef struct {
    int          q;
    logic [31:0] addr;
    int          size;
    logic        nocrc;
    int          exp_size;
    logic        exp_ov;
    logic        exp_dma;
    int          exp_lat;
  } vec_t;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic [NQ-1:0] q_empty = '1;
  logic [NQ-1:0] q_rd_en;
  logic [NQ*AW-1:0] q_addr = '0;
  logic [NQ*SW-1:0] q_size = '0;
  logic [NQ-1:0] q_eof = '0;
  logic [NQ-1:0] q_nocrc = '0;
  logic dma_start, dma_cont, dma_busy = 1'b0;
  logic [AW-1:0] dma_addr;
  logic [SW-1:0] dma_len;
  logic meta_full = 1'b0, meta_wr_en, meta_nocrc, meta_oversize;
  logic [SW-1:0] meta_size;
  logic [1:0] meta_queue;
  logic oc_full = 1'b0, oc_wr_en, oc_eof;
  logic [AW-1:0] oc_addr;
  logic [SW-1:0] oc_size;
  logic [1:0] oc_queue;

  logic q8_empty = 1'b1, q8_rd_en;
  logic [31:0] q8_addr = '0;
  logic [7:0] q8_size = '0;
  logic q8_eof = 1'b0, q8_nocrc = 1'b0;
  logic d8_start, d8_cont;
  logic [31:0] d8_addr;
  logic [7:0] d8_len;
  logic m8_wr_en, m8_nocrc, m8_ov;
  logic [7:0] m8_size;
  logic m8_queue;
  logic o8_wr_en, o8_eof;
  logic [31:0] o8_addr;
  logic [7:0] o8_size;
  logic o8_queue;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  cookie_t fq[NQ][$];
  rec_t obs_rd[$], obs_dma[$], obs_oc[$], obs_meta[$];
  rec_t exp_rd[$], exp_dma[$], exp_oc[$], exp_meta[$];
  vec_t vecs[5];

  prism_sp_puzzle_hw_gem_dma_read_mq #(
    .NUM_QUEUES(NQ), .ADDR_WIDTH(AW), .SIZE_WIDTH(SW),
    .MAX_FRAME_LEN(1536)
  ) dut (
    .clock(clock), .resetn(resetn),
    .q_empty(q_empty), .q_rd_en(q_rd_en),
    .q_addr(q_addr), .q_size(q_size),
    .q_eof(q_eof), .q_nocrc(q_nocrc),
    .dma_start(dma_start), .dma_addr(dma_addr),
    .dma_len(dma_len), .dma_cont(dma_cont),
    .dma_busy(dma_busy), .meta_full(meta_full),
    .meta_wr_en(meta_wr_en), .meta_size(meta_size),
    .meta_nocrc(meta_nocrc), .meta_oversize(meta_oversize),
    .meta_queue(meta_queue), .oc_full(oc_full),
    .oc_wr_en(oc_wr_en), .oc_addr(oc_addr),
    .oc_size(oc_size), .oc_eof(oc_eof), .oc_queue(oc_queue)
  );

  prism_sp_puzzle_hw_gem_dma_read_mq #(
    .NUM_QUEUES(1), .ADDR_WIDTH(32), .SIZE_WIDTH(8),
    .MAX_FRAME_LEN(1536)
  ) dut8 (
    .clock(clock), .resetn(resetn),
    .q_empty(q8_empty), .q_rd_en(q8_rd_en),
    .q_addr(q8_addr), .q_size(q8_size),
    .q_eof(q8_eof), .q_nocrc(q8_nocrc),
    .dma_start(d8_start), .dma_addr(d8_addr),
    .dma_len(d8_len), .dma_cont(d8_cont),
    .dma_busy(1'b0), .meta_full(1'b0),
    .meta_wr_en(m8_wr_en), .meta_size(m8_size),
    .meta_nocrc(m8_nocrc), .meta_oversize(m8_ov),
    .meta_queue(m8_queue), .oc_full(1'b0),
    .oc_wr_en(o8_wr_en), .oc_addr(o8_addr),
    .oc_size(o8_size), .oc_eof(o8_eof), .oc_queue(o8_queue)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: record output events, pop consumed cookies, present heads.
  always @(negedge clock) begin
    rec_t r;
    r = '{cyc: cyc, q: 0, addr: '0, size: '0, f1: 1'b0, f2: 1'b0};
    for (int q = 0; q < NQ; q++) begin
      if (q_rd_en[q]) begin
        r.q = q;
        obs_rd.push_back(r);
        if (fq[q].size() > 0) void'(fq[q].pop_front());
      end
    end
    if (dma_start) begin
      r.addr = dma_addr; r.size = dma_len; r.f1 = dma_cont;
      obs_dma.push_back(r);
    end
    if (oc_wr_en) begin
      r.addr = oc_addr; r.size = oc_size; r.f1 = oc_eof;
      r.q = int'(oc_queue);
      obs_oc.push_back(r);
    end
    if (meta_wr_en) begin
      r.addr = '0; r.size = meta_size; r.f1 = meta_nocrc;
      r.f2 = meta_oversize; r.q = int'(meta_queue);
      obs_meta.push_back(r);
    end
    for (int q = 0; q < NQ; q++) begin
      if (fq[q].size() > 0) begin
        q_empty[q] = 1'b0;
        q_addr[q*AW +: AW] = fq[q][0].addr;
        q_size[q*SW +: SW] = SW'(fq[q][0].size);
        q_eof[q] = fq[q][0].eof;
        q_nocrc[q] = fq[q][0].nocrc;
      end else begin
        q_empty[q] = 1'b1;
        q_addr[q*AW +: AW] = '0;
        q_size[q*SW +: SW] = '0;
        q_eof[q] = 1'b0;
        q_nocrc[q] = 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic push(input int q, input logic [31:0] a, input int s,
                      input logic e, input logic n);
    cookie_t c;
    c.addr = a; c.size = s; c.eof = e; c.nocrc = n;
    fq[q].push_back(c);
  endtask

  task automatic clear_obs();
    obs_rd.delete(); obs_dma.delete();
    obs_oc.delete(); obs_meta.delete();
  endtask

  task automatic do_reset();
    @(negedge clock);
    resetn = 1'b0;
    meta_full = 1'b0; oc_full = 1'b0; dma_busy = 1'b0;
    for (int q = 0; q < NQ; q++) fq[q].delete();
    repeat (2) @(negedge clock);
    clear_obs();
  endtask

  task automatic release_rst();
    @(negedge clock);
    resetn = 1'b1;
  endtask

  task automatic wait_meta(input int n, input int budget);
    int t = 0;
    while (obs_meta.size() < n && t < budget) begin
      @(negedge clock);
      t++;
    end
    @(negedge clock);
    chk("wait_meta", 64'(obs_meta.size() >= n), 64'd1);
  endtask

  // Reference: frames leave queues whole, in round-robin order.
  task automatic build_model();
    cookie_t mq[NQ][$];
    int ptr = 0;
    int found, q, sum;
    logic nc;
    rec_t r;
    for (int i = 0; i < NQ; i++) mq[i] = fq[i];
    exp_rd.delete(); exp_dma.delete();
    exp_oc.delete(); exp_meta.delete();
    forever begin
      found = 0; q = 0;
      for (int k = 0; k < NQ; k++) begin
        if (!found && mq[(ptr + k) % NQ].size() > 0) begin
          found = 1; q = (ptr + k) % NQ;
        end
      end
      if (!found) break;
      sum = 0;
      nc = mq[q][0].nocrc;
      forever begin
        cookie_t c = mq[q].pop_front();
        r = '{cyc: 0, q: q, addr: c.addr, size: 14'(c.size),
              f1: ~c.eof, f2: 1'b0};
        exp_rd.push_back(r);
        if (c.size != 0) exp_dma.push_back(r);
        r.f1 = c.eof;
        exp_oc.push_back(r);
        sum += c.size;
        if (c.eof) break;
      end
      r.addr = '0;
      r.size = (sum > 16383) ? 14'h3fff : 14'(sum);
      r.f1 = nc;
      r.f2 = (sum > 1536);
      exp_meta.push_back(r);
      ptr = (q + 1) % NQ;
    end
  endtask

  initial begin
    int t, c0;
    vecs[0] = '{0, 32'h1000, 64, 1'b1, 64, 1'b0, 1'b1, 3};
    vecs[1] = '{2, 32'h2000, 1536, 1'b0, 1536, 1'b0, 1'b1, 3};
    vecs[2] = '{3, 32'h3000, 1537, 1'b1, 1537, 1'b1, 1'b1, 3};
    vecs[3] = '{1, 32'h0040, 0, 1'b0, 0, 1'b0, 1'b0, 1};
    vecs[4] = '{0, 32'h5000, 16383, 1'b0, 16383, 1'b1, 1'b1, 3};

    // Reset state
    do_reset();
    chk("rst_pulses", {q_rd_en, dma_start, meta_wr_en, oc_wr_en}, '0);
    chk("rst_data", {dma_len, meta_size, oc_size, oc_addr}, '0);
    release_rst();

    // Table-driven single-fragment frames
    for (int i = 0; i < 5; i++) begin
      clear_obs();
      push(vecs[i].q, vecs[i].addr, vecs[i].size, 1'b1, vecs[i].nocrc);
      wait_meta(1, 60);
      if (obs_meta.size() >= 1 && obs_rd.size() >= 1 &&
          obs_oc.size() >= 1) begin
        chk($sformatf("v%0d_msize", i), obs_meta[0].size,
            vecs[i].exp_size);
        chk($sformatf("v%0d_mov", i), obs_meta[0].f2, vecs[i].exp_ov);
        chk($sformatf("v%0d_mnocrc", i), obs_meta[0].f1, vecs[i].nocrc);
        chk($sformatf("v%0d_mq", i), obs_meta[0].q, vecs[i].q);
        chk($sformatf("v%0d_rdq", i), obs_rd[0].q, vecs[i].q);
        chk($sformatf("v%0d_oc", i),
            {obs_oc[0].addr, obs_oc[0].size, obs_oc[0].f1},
            {vecs[i].addr, 14'(vecs[i].size), 1'b1});
        chk($sformatf("v%0d_ndma", i), obs_dma.size(), vecs[i].exp_dma);
        chk($sformatf("v%0d_lat", i), obs_meta[0].cyc - obs_rd[0].cyc,
            vecs[i].exp_lat);
        if (vecs[i].exp_dma && obs_dma.size() >= 1)
          chk($sformatf("v%0d_dma", i),
              {obs_dma[0].addr, obs_dma[0].size, obs_dma[0].f1,
               32'(obs_dma[0].cyc - obs_rd[0].cyc)},
              {vecs[i].addr, 14'(vecs[i].size), 1'b0, 32'd0});
      end
    end

    // Back-to-back frames on q0: 4-cycle turnaround
    do_reset();
    push(0, 32'h1000, 64, 1'b1, 1'b1);
    push(0, 32'h1100, 64, 1'b1, 1'b0);
    release_rst();
    wait_meta(2, 60);
    if (obs_rd.size() >= 2)
      chk("b2b_gap", obs_rd[1].cyc - obs_rd[0].cyc, 4);

    // Fragmented q1 frame while q2 waits
    do_reset();
    push(1, 32'h100, 100, 1'b0, 1'b1);
    push(1, 32'h200, 200, 1'b0, 1'b0);
    push(1, 32'h300, 300, 1'b1, 1'b0);
    push(2, 32'h400, 50, 1'b1, 1'b0);
    release_rst();
    wait_meta(2, 80);
    if (obs_rd.size() >= 4 && obs_dma.size() >= 3 && obs_meta.size() >= 2)
    begin
      chk("frag_order", {obs_rd[0].q[3:0], obs_rd[1].q[3:0],
          obs_rd[2].q[3:0], obs_rd[3].q[3:0]}, 16'h1112);
      chk("frag_cont", {obs_dma[0].f1, obs_dma[1].f1, obs_dma[2].f1},
          3'b110);
      chk("frag_meta", {obs_meta[0].size, obs_meta[0].f1,
          obs_meta[0].q[3:0]}, {14'd600, 1'b1, 4'd1});
      chk("frag_meta2_q", obs_meta[1].q, 2);
    end

    // Round robin 0,1,2,3,0
    do_reset();
    for (int q = 0; q < NQ; q++) push(q, 32'(q * 16), 8, 1'b1, 1'b0);
    push(0, 32'h80, 8, 1'b1, 1'b0);
    release_rst();
    wait_meta(5, 100);
    if (obs_rd.size() >= 5)
      chk("rr_order", {obs_rd[0].q[3:0], obs_rd[1].q[3:0],
          obs_rd[2].q[3:0], obs_rd[3].q[3:0], obs_rd[4].q[3:0]},
          20'h01230);

    // Meta backpressure at eof
    do_reset();
    meta_full = 1'b1;
    push(0, 32'h1000, 64, 1'b1, 1'b0);
    push(1, 32'h2000, 32, 1'b1, 1'b0);
    release_rst();
    t = 0;
    while (obs_oc.size() < 1 && t < 40) begin
      @(negedge clock); t++;
    end
    repeat (6) @(negedge clock);
    chk("bp_nometa", obs_meta.size(), 0);
    chk("bp_nord", obs_rd.size(), 1);
    if (obs_oc.size() >= 1 && obs_rd.size() >= 1)
      chk("bp_oc_now", obs_oc[0].cyc - obs_rd[0].cyc, 3);
    meta_full = 1'b0;
    c0 = cyc;
    wait_meta(2, 60);
    if (obs_meta.size() >= 2 && obs_rd.size() >= 2) begin
      chk("bp_meta_cyc", obs_meta[0].cyc, c0 + 1);
      chk("bp_next_rd", obs_rd[1].cyc - obs_meta[0].cyc, 1);
    end

    // Zero-length fragment and oversize
    do_reset();
    push(0, 32'hA000, 1000, 1'b0, 1'b0);
    push(0, 32'hB000, 0, 1'b0, 1'b0);
    push(0, 32'hC000, 600, 1'b1, 1'b0);
    release_rst();
    wait_meta(1, 80);
    chk("zero_ndma", obs_dma.size(), 2);
    chk("zero_nrd", obs_rd.size(), 3);
    if (obs_meta.size() >= 1)
      chk("zero_meta", {obs_meta[0].size, obs_meta[0].f2},
          {14'd1600, 1'b1});

    // Reset in BUSY mid-frame
    do_reset();
    push(0, 32'h10, 10, 1'b1, 1'b0);
    release_rst();
    wait_meta(1, 40);
    dma_busy = 1'b1;
    push(1, 32'h20, 20, 1'b0, 1'b0);
    push(1, 32'h30, 30, 1'b1, 1'b0);
    t = 0;
    while (obs_rd.size() < 2 && t < 40) begin
      @(negedge clock); t++;
    end
    repeat (3) @(negedge clock);
    chk("mid_no_meta", obs_meta.size(), 1);
    resetn = 1'b0;
    @(negedge clock);
    chk("midrst_pulses", {q_rd_en, dma_start, meta_wr_en, oc_wr_en}, '0);
    chk("midrst_data", {dma_len, oc_size, oc_addr}, '0);
    push(0, 32'h40, 40, 1'b1, 1'b0);
    dma_busy = 1'b0;
    clear_obs();
    @(negedge clock);
    resetn = 1'b1;
    wait_meta(1, 40);
    if (obs_rd.size() >= 1 && obs_meta.size() >= 1) begin
      chk("midrst_q0", obs_rd[0].q, 0);
      chk("midrst_acc", {obs_meta[0].size, obs_meta[0].q[3:0]},
          {14'd40, 4'd0});
    end

    // Randomized frames with random backpressure
    do_reset();
    for (int f = 0; f < 30; f++) begin
      int q, nf, s, r;
      q = $urandom_range(0, NQ - 1);
      nf = $urandom_range(1, 3);
      for (int k = 0; k < nf; k++) begin
        r = $urandom_range(0, 9);
        if (r == 0) s = 0;
        else if (r < 8) s = $urandom_range(1, 700);
        else if (r == 8) s = $urandom_range(1400, 1600);
        else s = $urandom_range(8000, 16383);
        push(q, $urandom, s, k == nf - 1, 1'($urandom));
      end
    end
    build_model();
    release_rst();
    t = 0;
    while (obs_meta.size() < exp_meta.size() && t < 20000) begin
      @(negedge clock);
      meta_full = ($urandom_range(0, 3) == 0);
      oc_full = ($urandom_range(0, 3) == 0);
      dma_busy = ($urandom_range(0, 2) == 0);
      t++;
    end
    meta_full = 1'b0; oc_full = 1'b0; dma_busy = 1'b0;
    repeat (10) @(negedge clock);
    chk("rnd_nmeta", obs_meta.size(), exp_meta.size());
    chk("rnd_nrd", obs_rd.size(), exp_rd.size());
    chk("rnd_ndma", obs_dma.size(), exp_dma.size());
    chk("rnd_noc", obs_oc.size(), exp_oc.size());
    for (int i = 0; i < exp_rd.size() && i < obs_rd.size(); i++)
      chk($sformatf("rnd_rd%0d", i), obs_rd[i].q, exp_rd[i].q);
    for (int i = 0; i < exp_dma.size() && i < obs_dma.size(); i++)
      chk($sformatf("rnd_dma%0d", i),
          {obs_dma[i].addr, obs_dma[i].size, obs_dma[i].f1},
          {exp_dma[i].addr, exp_dma[i].size, exp_dma[i].f1});
    for (int i = 0; i < exp_oc.size() && i < obs_oc.size(); i++)
      chk($sformatf("rnd_oc%0d", i),
          {obs_oc[i].addr, obs_oc[i].size, obs_oc[i].f1,
           obs_oc[i].q[3:0]},
          {exp_oc[i].addr, exp_oc[i].size, exp_oc[i].f1,
           exp_oc[i].q[3:0]});
    for (int i = 0; i < exp_meta.size() && i < obs_meta.size(); i++)
      chk($sformatf("rnd_meta%0d", i),
          {obs_meta[i].size, obs_meta[i].f1, obs_meta[i].f2,
           obs_meta[i].q[3:0]},
          {exp_meta[i].size, exp_meta[i].f1, exp_meta[i].f2,
           exp_meta[i].q[3:0]});

    // 8-bit size instance: 200 + 100 saturates
    do_reset();
    q8_empty = 1'b0; q8_size = 8'd200; q8_eof = 1'b0;
    q8_addr = 32'h7000;
    release_rst();
    begin
      int nrd = 0;
      int nm = 0;
      logic [7:0] ms = '0;
      logic mo = 1'b0;
      t = 0;
      while (nm == 0 && t < 60) begin
        @(negedge clock);
        t++;
        if (q8_rd_en) begin
          nrd++;
          if (nrd == 1) begin
            q8_size = 8'd100; q8_eof = 1'b1;
          end else begin
            q8_empty = 1'b1;
          end
        end
        if (m8_wr_en) begin
          nm++; ms = m8_size; mo = m8_ov;
        end
      end
      chk("w8_meta_seen", 64'(nm), 64'd1);
      chk("w8_nrd", 64'(nrd), 64'd2);
      chk("w8_meta", {ms, mo, m8_queue}, {8'd255, 1'b1, 1'b0});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
